// File: rtl/vx_tcu_drl_fpadd_pipe.sv
// rtl/vx_tcu_drl_fpadd_pipe.sv - 3-stage multi-lane IEEE-754 adder/subtractor with RNE and flush-to-zero
// Optional VX_TCU_FPADD_FLAGS_EN adds fflags_out {NV, DZ, OF, UF, NX} OR-reduced across lanes.
module vx_tcu_drl_fpadd_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int LANES = 4,
    parameter int TAG_W = 8
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               valid_in,
    output logic                               ready_in,
    input  logic                               sub_in,
    input  logic [LANES*(1+EXP_W+MAN_W)-1:0]   a_in,
    input  logic [LANES*(1+EXP_W+MAN_W)-1:0]   b_in,
    input  logic [TAG_W-1:0]                   tag_in,
    output logic                               valid_out,
    input  logic                               ready_out,
    output logic [LANES*(1+EXP_W+MAN_W)-1:0]   y_out,
    output logic [TAG_W-1:0]                   tag_out
`ifdef VX_TCU_FPADD_FLAGS_EN
    ,
    output logic [4:0]                         fflags_out
`endif
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int DW  = MAN_W + 4;
    localparam int EW  = EXP_W + 2;
    localparam int LZW = $clog2(DW + 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    logic             adv;
    logic             v1, v2, v3;
    logic [TAG_W-1:0] t1, t2;

    // The whole pipe advances together; bubbles hold too when stalled.
    assign adv       = ~v3 | ready_out;
    assign ready_in  = adv;
    assign valid_out = v3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            t1      <= '0;
            t2      <= '0;
            tag_out <= '0;
        end else if (adv) begin
            v1      <= valid_in;
            v2      <= v1;
            v3      <= v2;
            t1      <= tag_in;
            t2      <= t1;
            tag_out <= t2;
        end
    end

`ifdef VX_TCU_FPADD_FLAGS_EN
    logic [4:0] lane_fl [LANES];
    logic [4:0] fl_or;

    always_comb begin
        fl_or = '0;
        for (int i = 0; i < LANES; i++) fl_or = fl_or | lane_fl[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  fflags_out <= '0;
        else if (adv)  fflags_out <= fl_or;
    end
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [W-1:0]     a, b;
        logic             sa, sb;
        logic [EXP_W-1:0] ea, eb;
        logic [MAN_W-1:0] fa, fb;
        logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
        logic             c1_spec;
        logic [W-1:0]     c1_sval;

        assign a      = a_in[i*W +: W];
        assign b      = b_in[i*W +: W];
        assign sa     = a[W-1];
        assign sb     = b[W-1] ^ sub_in;
        assign ea     = a[W-2:MAN_W];
        assign eb     = b[W-2:MAN_W];
        assign fa     = a[MAN_W-1:0];
        assign fb     = b[MAN_W-1:0];
        assign a_zero = (ea == '0);
        assign b_zero = (eb == '0);
        assign a_inf  = (ea == EXP_ONES) && (fa == '0);
        assign b_inf  = (eb == EXP_ONES) && (fb == '0);
        assign a_nan  = (ea == EXP_ONES) && (fa != '0);
        assign b_nan  = (eb == EXP_ONES) && (fb != '0);
        assign a_big  = {ea, fa} >= {eb, fb};

        // Specials resolved up front; denormals behave as signed zeros.
        always_comb begin
            c1_spec = 1'b1;
            c1_sval = '0;
            if (a_nan | b_nan | (a_inf & b_inf & (sa != sb)))
                c1_sval = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            else if (a_inf)           c1_sval = {sa, ea, fa};
            else if (b_inf)           c1_sval = {sb, eb, fb};
            else if (a_zero & b_zero) c1_sval = {sa & sb, {(W-1){1'b0}}};
            else if (b_zero)          c1_sval = {sa, ea, fa};
            else if (a_zero)          c1_sval = {sb, eb, fb};
            else                      c1_spec = 1'b0;
        end

        logic             s1_spec, s1_sign, s1_sub;
        logic [W-1:0]     s1_sval;
        logic [EXP_W-1:0] s1_exp, s1_diff;
        logic [MAN_W:0]   s1_mbig, s1_msml;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1_spec <= 1'b0;
                s1_sval <= '0;
                s1_sign <= 1'b0;
                s1_sub  <= 1'b0;
                s1_exp  <= '0;
                s1_diff <= '0;
                s1_mbig <= '0;
                s1_msml <= '0;
            end else if (adv) begin
                s1_spec <= c1_spec;
                s1_sval <= c1_sval;
                s1_sign <= a_big ? sa : sb;
                s1_sub  <= sa ^ sb;
                s1_exp  <= a_big ? ea : eb;
                s1_diff <= a_big ? (ea - eb) : (eb - ea);
                s1_mbig <= a_big ? {1'b1, fa} : {1'b1, fb};
                s1_msml <= a_big ? {1'b1, fb} : {1'b1, fa};
            end
        end

        logic [DW-1:0] big_x, sml_x, sml_sh, sh_mask;
        logic [DW:0]   sum;

        always_comb begin
            big_x   = {s1_mbig, 3'b000};
            sml_x   = {s1_msml, 3'b000};
            sh_mask = '0;
            if ({{(32-EXP_W){1'b0}}, s1_diff} >= 32'(MAN_W + 3)) begin
                sml_sh = {{(DW-1){1'b0}}, 1'b1};
            end else begin
                sh_mask = ~({DW{1'b1}} << s1_diff);
                sml_sh  = (sml_x >> s1_diff) | {{(DW-1){1'b0}}, |(sml_x & sh_mask)};
            end
            sum = s1_sub ? ({1'b0, big_x} - {1'b0, sml_sh})
                         : ({1'b0, big_x} + {1'b0, sml_sh});
        end

        logic             s2_spec, s2_sign;
        logic [W-1:0]     s2_sval;
        logic [EXP_W-1:0] s2_exp;
        logic [DW:0]      s2_sum;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s2_spec <= 1'b0;
                s2_sval <= '0;
                s2_sign <= 1'b0;
                s2_exp  <= '0;
                s2_sum  <= '0;
            end else if (adv) begin
                s2_spec <= s1_spec;
                s2_sval <= s1_sval;
                s2_sign <= s1_sign;
                s2_exp  <= s1_exp;
                s2_sum  <= sum;
            end
        end

        logic [LZW-1:0]   lz;
        logic [DW-1:0]    m;
        logic [EW-1:0]    e_n, e_r;
        logic [MAN_W+1:0] rnd;
        logic [MAN_W-1:0] frac;
        logic             inc, ovf, unf, lost;
        logic [W-1:0]     y_c, y_q;

        always_comb begin
            lz = '0;
            for (int k = 0; k < DW; k++)
                if (s2_sum[k]) lz = LZW'(DW - 1 - k);
            if (s2_sum[DW]) begin
                m   = {s2_sum[DW:2], s2_sum[1] | s2_sum[0]};
                e_n = {2'b00, s2_exp} + {{(EW-1){1'b0}}, 1'b1};
            end else begin
                m   = s2_sum[DW-1:0] << lz;
                e_n = {2'b00, s2_exp} - EW'(lz);
            end
            // m layout: hidden, fraction, then guard/round/sticky in [2:0].
            lost = m[2] | m[1] | m[0];
            inc  = m[2] & (m[1] | m[0] | m[3]);
            rnd  = {1'b0, m[DW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
            e_r  = e_n + {{(EW-1){1'b0}}, rnd[MAN_W+1]};
            frac = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
            ovf  = ~e_r[EW-1] && (e_r >= {2'b00, EXP_ONES});
            unf  = e_r[EW-1] || (e_r == '0);
            if (s2_spec)             y_c = s2_sval;
            else if (s2_sum == '0)   y_c = '0;
            else if (ovf)            y_c = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            else if (unf)            y_c = {s2_sign, {(W-1){1'b0}}};
            else                     y_c = {s2_sign, e_r[EXP_W-1:0], frac};
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)  y_q <= '0;
            else if (adv)  y_q <= y_c;
        end

        assign y_out[i*W +: W] = y_q;

`ifdef VX_TCU_FPADD_FLAGS_EN
        logic c1_nv, s1_nv, s2_nv;
        logic [4:0] fl_c;

        assign c1_nv = (a_nan & ~fa[MAN_W-1]) | (b_nan & ~fb[MAN_W-1]) | (a_inf & b_inf & (sa != sb));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1_nv <= 1'b0;
                s2_nv <= 1'b0;
            end else if (adv) begin
                s1_nv <= c1_nv;
                s2_nv <= s1_nv;
            end
        end

        always_comb begin
            fl_c = '0;
            if (s2_spec)            fl_c[4] = s2_nv;
            else if (s2_sum == '0)  fl_c = '0;
            else if (ovf)           fl_c = 5'b00101;
            else if (unf)           fl_c = 5'b00011;
            else                    fl_c[0] = lost;
        end

        assign lane_fl[i] = fl_c;
`endif
    end
endmodule

// File: tb/tb_vx_tcu_drl_fpadd_pipe.sv
// tb/tb_vx_tcu_drl_fpadd_pipe.sv - scoreboard bench: fp32 x4 lanes plus fp16 x2 lanes instance
module tb_vx_tcu_drl_fpadd_pipe;
    localparam int YW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, valid_in, ready_in, sub_in, valid_out, ready_out;
    logic [YW-1:0] a_in, b_in, y_out;
    logic [7:0]    tag_in, tag_out;

    logic          rst16_n, v16_in, r16_in, s16_in, v16_out, r16_out;
    logic [31:0]   a16, b16, y16;
    logic [7:0]    t16_in, t16_out;

`ifdef VX_TCU_FPADD_FLAGS_EN
    logic [4:0]    fflags, fflags16;
`endif

    vx_tcu_drl_fpadd_pipe dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .ready_in(ready_in),
        .sub_in(sub_in), .a_in(a_in), .b_in(b_in), .tag_in(tag_in),
        .valid_out(valid_out), .ready_out(ready_out), .y_out(y_out), .tag_out(tag_out)
`ifdef VX_TCU_FPADD_FLAGS_EN
        , .fflags_out(fflags)
`endif
    );

    vx_tcu_drl_fpadd_pipe #(.EXP_W(5), .MAN_W(10), .LANES(2), .TAG_W(8)) dut16 (
        .clk(clk), .reset_n(rst16_n), .valid_in(v16_in), .ready_in(r16_in),
        .sub_in(s16_in), .a_in(a16), .b_in(b16), .tag_in(t16_in),
        .valid_out(v16_out), .ready_out(r16_out), .y_out(y16), .tag_out(t16_out)
`ifdef VX_TCU_FPADD_FLAGS_EN
        , .fflags_out(fflags16)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [135:0] sb_q[$];

    logic          vec_sub [6];
    logic [YW-1:0] vec_a [6];
    logic [YW-1:0] vec_b [6];
    logic [YW-1:0] vec_y [6];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input int idx, input logic [7:0] tag);
        bit done = 1'b0;
        valid_in = 1'b1;
        sub_in   = vec_sub[idx];
        a_in     = vec_a[idx];
        b_in     = vec_b[idx];
        tag_in   = tag;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            done = ready_in;
            @(posedge clk);
            #1;
        end
        check_eq("accept", 128'(done), 128'(1));
        if (done) sb_q.push_back({tag, vec_y[idx]});
        valid_in = 1'b0;
    endtask

    // Output side: compare the queue head whenever a result is presented, pop on transfer.
    always @(negedge clk) begin
        logic [135:0] e;
        if (reset_n && valid_out) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious", 128'(valid_out), 128'(0));
            end else begin
                e = sb_q[0];
                check_eq("y", y_out, e[127:0]);
                check_eq("tag", 128'(tag_out), 128'(e[135:128]));
                if (ready_out) void'(sb_q.pop_front());
                else check_eq("stall_ready_in", 128'(ready_in), 128'(0));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  lat;
        bit  seen;
        bit  acc;
        vec_sub[0] = 1'b0;
        vec_a[0] = {32'h7F800000, 32'h3F800001, 32'h3F800000, 32'h3F800000};
        vec_b[0] = {32'h00000000, 32'h33800000, 32'h33800000, 32'h40000000};
        vec_y[0] = {32'h7F800000, 32'h3F800002, 32'h3F800000, 32'h40400000};
        vec_sub[1] = 1'b1;
        vec_a[1] = {32'h3F800000, 32'h40400000, 32'h3F800000, 32'h7F800000};
        vec_b[1] = {32'h40000000, 32'h3F800000, 32'h3F800000, 32'h7F800000};
        vec_y[1] = {32'hBF800000, 32'h40000000, 32'h00000000, 32'h7FC00000};
        vec_sub[2] = 1'b0;
        vec_a[2] = {32'h7FC00000, 32'h00000000, 32'h80000000, 32'h7F7FFFFF};
        vec_b[2] = {32'h3F800000, 32'h80000000, 32'h80000000, 32'h7F7FFFFF};
        vec_y[2] = {32'h7FC00000, 32'h00000000, 32'h80000000, 32'h7F800000};
        vec_sub[3] = 1'b0;
        vec_a[3] = {32'h41200000, 32'h3F800000, 32'hFF800000, 32'h3F800000};
        vec_b[3] = {32'hC0A00000, 32'hBF800000, 32'h3F800000, 32'h00400000};
        vec_y[3] = {32'h40A00000, 32'h00000000, 32'hFF800000, 32'h3F800000};
        vec_sub[4] = 1'b1;
        vec_a[4] = {32'h3FC00000, 32'h7F800000, 32'h80000000, 32'h00000000};
        vec_b[4] = {32'h3F000000, 32'hFF800000, 32'h00000000, 32'h00000000};
        vec_y[4] = {32'h3F800000, 32'h7F800000, 32'h80000000, 32'h00000000};
        vec_sub[5] = 1'b1;
        vec_a[5] = {32'h4B800001, 32'h4B800000, 32'h00800000, 32'h3F800001};
        vec_b[5] = {32'hBF800000, 32'hBF800000, 32'h00800001, 32'h3F800000};
        vec_y[5] = {32'h4B800002, 32'h4B800000, 32'h80000000, 32'h34000000};

        reset_n = 1'b0; valid_in = 1'b0; sub_in = 1'b0; a_in = '0; b_in = '0;
        tag_in = '0; ready_out = 1'b1;
        rst16_n = 1'b0; v16_in = 1'b0; s16_in = 1'b0; a16 = '0; b16 = '0;
        t16_in = '0; r16_out = 1'b1;

        #12;
        check_eq("rst_valid_out", 128'(valid_out), 128'(0));
        check_eq("rst_y_out", y_out, '0);
        check_eq("rst_tag_out", 128'(tag_out), 128'(0));
        @(posedge clk); #1;
        reset_n = 1'b1; rst16_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_ready_in", 128'(ready_in), 128'(1));

        send(0, 8'h5A);
        lat = 1;
        while (!valid_out && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", 128'(lat), 128'(3));
        repeat (4) @(posedge clk);
        #1;

        for (int i = 1; i < 6; i++) send(i, 8'h20 + 8'(i));

        fork
            begin
                for (int i = 0; i < 8; i++) send(i % 6, 8'h80 + 8'(i));
            end
            begin
                repeat (4) @(posedge clk);
                #1 ready_out = 1'b0;
                repeat (5) @(posedge clk);
                #1 ready_out = 1'b1;
            end
        join

        for (int k = 0; k < 100 && sb_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check_eq("drain", 128'(sb_q.size()), 128'(0));

        v16_in = 1'b1; s16_in = 1'b0; t16_in = 8'h11;
        a16 = {16'h7BFF, 16'h3C00};
        b16 = {16'h7BFF, 16'h3C00};
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk); acc = r16_in;
            @(posedge clk); #1;
        end
        v16_in = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (v16_out) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check_eq("fp16_valid", 128'(seen), 128'(1));
        check_eq("fp16_y", 128'(y16), 128'({16'h7C00, 16'h4000}));
        check_eq("fp16_tag", 128'(t16_out), 128'(8'h11));
        @(posedge clk); #1;

        v16_in = 1'b1; t16_in = 8'h22;
        repeat (3) @(posedge clk);
        #1;
        check_eq("fp16_pre_rst_valid", 128'(v16_out), 128'(1));
        #2;
        rst16_n = 1'b0;
        v16_in = 1'b0;
        #1;
        check_eq("fp16_rst_valid", 128'(v16_out), 128'(0));
        check_eq("fp16_rst_y", 128'(y16), 128'(0));
        check_eq("fp16_rst_tag", 128'(t16_out), 128'(0));
        @(posedge clk); #1;
        rst16_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            seen = seen | v16_out;
        end
        check_eq("fp16_no_replay", 128'(seen), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
